// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic TXD_IDLE  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // The extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_level == (AW+1)'(DEPTH));
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered 8-N-1/8-N-2 UART transmitter with a fixed clock divisor.
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | line high for STOP_BITS*CLK_DIV cycles; may chain into START
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int            CW        = $clog2(STOP_BITS*CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV-1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS*CLK_DIV-1);

  tx_state_t             r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [2:0]            r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_bit_end;
  logic                  w_stop_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (in_valid),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

  assign in_ready   = !w_full;
  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_stop_end = (r_cnt == STOP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'(DATA_BITS-1)) w_state_nxt = STOP;
        end
      end
      STOP: begin
        // Popping on the last stop cycle chains frames with no idle gap.
        if (w_stop_end) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txd = TXD_IDLE;
    case (r_state)
      START:   txd = 1'b0;
      DATA:    txd = r_shift[0];
      default: txd = TXD_IDLE;
    endcase
  end

  assign tx_done = (r_state == STOP) && w_stop_end;
  assign busy    = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomised self-checking bench: cycle-exact frame model plus a UART receiver scoreboard.
module tb_uart_tx_serializer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       d1_in_valid = 1'b0;
  logic [7:0] d1_in_data = 8'h00;
  logic       d1_in_ready, d1_txd, d1_busy, d1_tx_done;
  logic [4:0] d1_level;

  logic       d2_in_valid = 1'b0;
  logic [7:0] d2_in_data = 8'h00;
  logic       d2_in_ready, d2_txd, d2_busy, d2_tx_done;
  logic [4:0] d2_level;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_bad   = 0;
  int max_lvl  = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] mon_b;

  always #5 clk = ~clk;

  uart_tx_serializer #(.FIFO_DEPTH(16), .CLK_DIV(DIV), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_data(d1_in_data), .txd(d1_txd), .busy(d1_busy), .tx_done(d1_tx_done),
    .fifo_level(d1_level));

  uart_tx_serializer #(.FIFO_DEPTH(16), .CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .txd(d2_txd), .busy(d2_busy), .tx_done(d2_tx_done),
    .fifo_level(d2_level));

  // Expected line level k cycles into a frame: start, 8 data bits LSB first, stop bits.
  function automatic logic exp_txd(input logic [7:0] b, input int k);
    int bit_no;
    bit_no = k / DIV;
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no-1];
    return 1'b1;
  endfunction

  // Behavioural UART receiver on dut1: samples each bit at its centre.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && d1_txd === 1'b0) begin
        repeat (DIV/2) @(negedge clk);
        if (d1_txd !== 1'b0) rx_bad++;
        else begin
          for (int j = 0; j < 8; j++) begin
            repeat (DIV) @(negedge clk);
            mon_b[j] = d1_txd;
          end
          repeat (DIV) @(negedge clk);
          if (d1_txd !== 1'b1) rx_bad++;
          else rx_q.push_back(mon_b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (int'(d1_level) > max_lvl) max_lvl = int'(d1_level);
    end
  end

  // Offer one byte to dut1 starting at a negedge; returns at a negedge.
  task automatic offer(input logic [7:0] b, output bit ok);
    logic rdy;
    ok = 1'b0;
    d1_in_valid = 1'b1;
    d1_in_data  = b;
    for (int c = 0; c < 200; c++) begin
      rdy = d1_in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    d1_in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int c = 0; c < 3000 && rx_q.size() < n; c++) @(negedge clk);
    n_checks++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL rx_count: got %0d frames, expected %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    n_checks++;
    if ({d1_txd, d1_busy, d1_tx_done, d1_in_ready, d1_level} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_d1: txd=%b busy=%b done=%b rdy=%b lvl=%0d, expected 1 0 0 1 0",
               d1_txd, d1_busy, d1_tx_done, d1_in_ready, d1_level);
    end
    n_checks++;
    if ({d2_txd, d2_busy, d2_in_ready, d2_level} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_d2: txd=%b busy=%b rdy=%b lvl=%0d", d2_txd, d2_busy, d2_in_ready, d2_level);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    logic [7:0] b = 8'h55;
    int bad = 0;
    int dones = 0;
    d1_in_valid = 1'b1;
    d1_in_data  = b;
    @(posedge clk);
    @(negedge clk);
    d1_in_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 10*DIV; k++) begin
      @(negedge clk);
      if (d1_txd !== exp_txd(b, k) || d1_busy !== 1'b1) bad++;
      if (d1_tx_done === 1'b1) begin
        dones++;
        if (k != 10*DIV-1) bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_wave: %0d bad cycles, expected 0", bad);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL single_done: %0d pulses, expected 1", dones);
    end
    @(negedge clk);
    n_checks++;
    if (d1_busy !== 1'b0 || d1_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b txd=%b, expected 0 1", d1_busy, d1_txd);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0 = 8'hA5;
    logic [7:0] b1 = 8'h3C;
    int bad = 0;
    int done_at [$];
    @(negedge clk);
    d1_in_valid = 1'b1;
    d1_in_data  = b0;
    @(posedge clk);
    @(negedge clk);
    d1_in_data = b1;
    @(posedge clk);
    for (int k = 0; k < 20*DIV; k++) begin
      @(negedge clk);
      d1_in_valid = 1'b0;
      if (k < 10*DIV) begin
        if (d1_txd !== exp_txd(b0, k)) bad++;
      end else begin
        if (d1_txd !== exp_txd(b1, k - 10*DIV)) bad++;
      end
      if (d1_tx_done === 1'b1) done_at.push_back(k);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_wave: %0d bad cycles, expected 0", bad);
    end
    n_checks++;
    if (done_at.size() != 2 || done_at[0] != 10*DIV-1 || done_at[1] != 20*DIV-1) begin
      n_fail++;
      $display("FAIL b2b_done: %0d pulses (first at %0d), expected 2 at 39 and 79",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_fifo;
    int idx = 0;
    bit seen_full = 0;
    logic rdy;
    logic [4:0] lvl;
    rx_q.delete();
    exp_q.delete();
    rx_bad = 0;
    d1_in_valid = 1'b1;
    d1_in_data  = 8'h00;
    for (int c = 0; c < 2000 && idx < 20; c++) begin
      rdy = d1_in_ready;
      lvl = d1_level;
      if (!rdy && !seen_full) begin
        seen_full = 1;
        n_checks++;
        if (lvl !== 5'd16 || idx != 17) begin
          n_fail++;
          $display("FAIL full_point: level=%0d accepted=%0d, expected 16 17", lvl, idx);
        end
      end
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(d1_in_data);
        idx++;
      end
      @(negedge clk);
      if (idx < 20) d1_in_data = 8'(idx);
      else d1_in_valid = 1'b0;
    end
    d1_in_valid = 1'b0;
    n_checks++;
    if (!seen_full || idx != 20) begin
      n_fail++;
      $display("FAIL full_accept: seen_full=%0d accepted=%0d, expected 1 20", seen_full, idx);
    end
    wait_rx(20);
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_data[%0d]: got %02h, expected %02h", i, rx_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (rx_bad != 0) begin
      n_fail++;
      $display("FAIL full_framing: %0d framing errors, expected 0", rx_bad);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int bad = 0;
    bit ok;
    d1_in_valid = 1'b1;
    d1_in_data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    d1_in_valid = 1'b0;
    d1_in_data  = 8'h12;
    @(posedge clk);
    for (int k = 0; k <= 4*DIV + 1; k++) @(negedge clk);
    n_checks++;
    if (d1_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: txd=%b during data bit 3 of FF, expected 1", d1_txd);
    end
    d1_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d1_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (d1_txd !== 1'b1 || d1_level !== 5'd0 || d1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: txd=%b level=%0d busy=%b, expected 1 0 0", d1_txd, d1_level, d1_busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (d1_txd !== 1'b1 || d1_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_residual: %0d active cycles after release, expected 0", bad);
    end
    rx_q.delete();
    rx_bad = 0;
    offer(8'h41, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_offer: byte 41 accepted=%0d, expected 1", ok);
    end
    wait_rx(1);
    n_checks++;
    if (rx_q.size() < 1 || rx_q[0] !== 8'h41 || rx_bad != 0) begin
      n_fail++;
      $display("FAIL abort_new: got %02h (errs %0d), expected 41", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_bad);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_two_stop;
    int bad = 0;
    int done_k = -1;
    @(negedge clk);
    d2_in_valid = 1'b1;
    d2_in_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    d2_in_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 11*DIV; k++) begin
      @(negedge clk);
      if (d2_txd !== ((k < 9*DIV) ? 1'b0 : 1'b1)) bad++;
      if (d2_tx_done === 1'b1) begin
        if (done_k >= 0) bad++;
        done_k = k;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stop2_wave: %0d bad cycles, expected 0", bad);
    end
    n_checks++;
    if (done_k != 11*DIV-1) begin
      n_fail++;
      $display("FAIL stop2_done: pulse at cycle %0d, expected %0d", done_k, 11*DIV-1);
    end
    @(negedge clk);
    n_checks++;
    if (d2_busy !== 1'b0 || d2_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL stop2_idle: busy=%b txd=%b, expected 0 1", d2_busy, d2_txd);
    end
  endtask

  task automatic test_wrap_random;
    bit ok;
    int n_ok = 0;
    rx_q.delete();
    exp_q.delete();
    rx_bad = 0;
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      offer(8'(i), ok);
      if (ok) begin
        exp_q.push_back(8'(i));
        n_ok++;
      end
    end
    n_checks++;
    if (n_ok != 40) begin
      n_fail++;
      $display("FAIL wrap_accept: %0d accepted, expected 40", n_ok);
    end
    wait_rx(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: got %02h, expected %02h", i, rx_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (max_lvl > 16 || rx_bad != 0) begin
      n_fail++;
      $display("FAIL wrap_level: max level %0d framing errs %0d, expected <=16 and 0", max_lvl, rx_bad);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (d1_level !== 5'd0 || d1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain: level=%0d busy=%b, expected 0 0", d1_level, d1_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
    test_two_stop();
    test_wrap_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
